multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  FSM main controller for a multi-cycle RV32I core; successor to the single-cycle opcode decoder.
//  Sequences fetch/decode/execute/memory/writeback with req/ack handshakes to instruction and data memory.
//  Bounds memory waits with a timeout and counts retired instructions. Drives datapath mux selects and write strobes.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles waiting for imem_ack/dmem_ack before bus error; 0 = no timeout
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous, active-high reset
//  opcode      in   7      instr[6:0]; sampled only while imem_ack=1 in FETCH
//  br_taken    in   1      branch condition from comparator, valid in EXEC
//  imem_ack    in   1      instruction memory ack
//  dmem_ack    in   1      data memory ack
//  imem_req    out  1      instruction fetch request
//  dmem_req    out  1      data access request
//  dmem_we     out  1      data write enable, qualified by dmem_req
//  ir_write    out  1      load instruction register
//  pc_write    out  1      update PC; marks retirement
//  pc_src      out  2      00 pc+4, 01 pc+imm (taken branch/JAL), 10 alu (JALR)
//  reg_write   out  1      register-file write strobe
//  imm_src     out  3      000 I, 001 S, 010 B, 011 J, 100 U
//  alu_src_a   out  2      00 rs1, 01 pc, 10 zero
//  alu_src_b   out  1      0 rs2, 1 imm
//  alu_op      out  2      00 add, 01 branch compare, 10 funct-decoded
//  wb_sel      out  2      00 alu, 01 mem data, 10 pc+4
//  instret     out  CNT_W  retired-instruction count, wraps
//  bus_err     out  1      sticky; memory timeout occurred
//  halted      out  1      controller in HALT
// BEHAVIOUR
//  - Reset (async): state IDLE; opcode class, wait_cnt, instret, bus_err := 0. All strobes/requests 0; selects 0.
//  - Moore outputs from state plus latched opcode class.
//  - IDLE -> FETCH, 1 cycle.
//  - FETCH: imem_req=1. On imem_ack: ir_write=1, latch class -> DECODE.
//  - DECODE: set imm_src per class -> EXEC.
//  - EXEC: alu selects per class. LOAD/STORE -> MEM (add, rs1+imm).
//    BRANCH -> FETCH with pc_write=1, pc_src=br_taken?01:00.
//    R/I/LUI(a=zero)/AUIPC(a=pc)/JAL/JALR -> WB.
//  - MEM: dmem_req=1, dmem_we=STORE. On dmem_ack: LOAD -> WB; STORE -> FETCH with pc_write=1, pc_src=00.
//  - WB: reg_write=1, pc_write=1; wb_sel 01 LOAD, 10 JAL/JALR, else 00; pc_src 01 JAL, 10 JALR, else 00 -> FETCH.
//  - Request held high until ack; a single-cycle ack completes the access. Ack outside FETCH/MEM is ignored.
//  - Latencies (incl. ack cycle, zero-wait memory): R/I/U/J 4 cycles, load 5, store 4, branch 3.
//  - instret += 1 in every cycle with pc_write=1; wraps to 0 at 2^CNT_W.
//  - wait_cnt: increments each FETCH/MEM cycle with req=1 and ack=0; cleared on ack or state exit.
//    When wait_cnt==MEM_WAIT_MAX (MEM_WAIT_MAX>0): bus_err:=1, go to HALT. Ack in that same cycle wins (no error).
//  - HALT: all strobes/requests 0, halted=1; exits only on reset.
//  - Reset mid-access drops the request immediately; no retirement counted.
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined:
//    - Unknown opcode -> HALT from DECODE; adds port illegal_op (out 1, sticky, reset 0).
//  MC_ILLEGAL_TRAP_EN undefined:
//    - Unknown opcode is a NOP: DECODE -> FETCH with pc_write=1, pc_src=00; instret counts it.
// STRUCTURE
//  - Package mc_ctrl_pkg: state_e {IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT}.
//  - Package mc_ctrl_pkg: op_class_e {LOAD,STORE,RTYPE,ITYPE,BRANCH,LUI,AUIPC,JAL,JALR,ILLEGAL}.
//  - Package mc_ctrl_pkg: opcode localparams; imm_src/pc_src/wb_sel/alu_op/alu_src_a encodings.
//  - Sub-module instr_classifier: combinational opcode -> op_class_e.
// TESTING
//  1. ADDI (0010011), zero-wait acks -> ir_write, DECODE, EXEC, WB: reg_write=1, wb_sel=00, pc_write=1; instret=1.
//  2. LW, dmem_ack after 3 wait cycles -> dmem_req held 4 cycles, dmem_we=0; WB wb_sel=01; instret+1.
//  3. BEQ with br_taken=1, then 0 -> pc_src=01, then 00, on EXEC cycle; reg_write never 1.
//  4. JALR -> WB: wb_sel=10, pc_src=10, reg_write=1. LUI -> alu_src_a=10, imm_src=100.
//  5. MEM_WAIT_MAX=4, imem_ack held 0 -> HALT after 4 wait cycles, bus_err=1, halted=1; ack at cycle 4 instead -> DECODE, no error.
//  6. Opcode 7'b1111111 -> with macro HALT + illegal_op=1; without, NOP retires (instret+1).
//     rst mid-MEM -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared types and encodings for the multi-cycle RV32I controller.
//             Holds the FSM state and opcode-class enumerations, the RV32I
//             major-opcode values, the datapath select encodings and a helper
//             that maps an opcode class onto its immediate format.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    // LOAD is deliberately the zero encoding: it is the reset class.
    typedef enum logic [3:0] {
        LOAD    = 4'd0,
        STORE   = 4'd1,
        RTYPE   = 4'd2,
        ITYPE   = 4'd3,
        BRANCH  = 4'd4,
        LUI     = 4'd5,
        AUIPC   = 4'd6,
        JAL     = 4'd7,
        JALR    = 4'd8,
        ILLEGAL = 4'd9
    } op_class_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_rtype  = 7'b0110011;
    localparam logic [6:0] c_opc_itype  = 7'b0010011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;

    // Immediate generator format
    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    // Next-PC source
    localparam logic [1:0] c_pc_plus4 = 2'b00;
    localparam logic [1:0] c_pc_imm   = 2'b01;
    localparam logic [1:0] c_pc_alu   = 2'b10;

    // Write-back source
    localparam logic [1:0] c_wb_alu = 2'b00;
    localparam logic [1:0] c_wb_mem = 2'b01;
    localparam logic [1:0] c_wb_pc4 = 2'b10;

    // ALU operation class
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_br    = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU operand A source
    localparam logic [1:0] c_srca_rs1  = 2'b00;
    localparam logic [1:0] c_srca_pc   = 2'b01;
    localparam logic [1:0] c_srca_zero = 2'b10;

    // R-type has no immediate; it reports the I format as a harmless default.
    function automatic logic [2:0] imm_src_for(input op_class_e cls);
        case (cls)
            STORE:       return c_imm_s;
            BRANCH:      return c_imm_b;
            JAL:         return c_imm_j;
            LUI, AUIPC:  return c_imm_u;
            default:     return c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller_if
//  Purpose  : Bundle of memory handshakes, instruction fields and datapath
//             controls between the multi-cycle controller and its datapath.
//             master = controller side, slave = datapath / memory side.
//  Signals  : opcode, br_taken, imem_ack, dmem_ack         (to controller)
//             imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
//             reg_write, imm_src, alu_src_a, alu_src_b, alu_op, wb_sel,
//             instret[CNT_W], bus_err, halted             (from controller)
//             illegal_op only when MC_ILLEGAL_TRAP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             br_taken;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [2:0]       imm_src;
    logic [1:0]       alu_src_a;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       wb_sel;
    logic [CNT_W-1:0] instret;
    logic             bus_err;
    logic             halted;
`ifdef MC_ILLEGAL_TRAP_EN
    logic             illegal_op;

    modport master (
        input  opcode, br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               reg_write, imm_src, alu_src_a, alu_src_b, alu_op, wb_sel,
               instret, bus_err, halted, illegal_op
    );
    modport slave (
        output opcode, br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               reg_write, imm_src, alu_src_a, alu_src_b, alu_op, wb_sel,
               instret, bus_err, halted, illegal_op
    );
`else
    modport master (
        input  opcode, br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               reg_write, imm_src, alu_src_a, alu_src_b, alu_op, wb_sel,
               instret, bus_err, halted
    );
    modport slave (
        output opcode, br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
               reg_write, imm_src, alu_src_a, alu_src_b, alu_op, wb_sel,
               instret, bus_err, halted
    );
`endif
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_instr_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : instr_classifier
//  Purpose  : Combinational map from the RV32I major opcode to an opcode
//             class. Anything not in RV32I base decodes as ILLEGAL.
//  Ports    : opcode   in  7   instr[6:0]
//             op_class out op_class_e
//  Revision : 1.0  initial release
// ============================================================================
module instr_classifier
    import mc_ctrl_pkg::*;
(
    input  wire logic [6:0] opcode,
    output op_class_e       op_class
);

    always_comb begin
        case (opcode)
            c_opc_load:   op_class = LOAD;
            c_opc_store:  op_class = STORE;
            c_opc_rtype:  op_class = RTYPE;
            c_opc_itype:  op_class = ITYPE;
            c_opc_branch: op_class = BRANCH;
            c_opc_lui:    op_class = LUI;
            c_opc_auipc:  op_class = AUIPC;
            c_opc_jal:    op_class = JAL;
            c_opc_jalr:   op_class = JALR;
            default:      op_class = ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Main FSM of a multi-cycle RV32I core. Sequences
//             FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction
//             and data memory, bounds memory waits with a timeout (sticky
//             bus_err, then HALT), counts retired instructions and drives the
//             datapath selects and write strobes.
//  Params   : MEM_WAIT_MAX  wait cycles tolerated before bus error (0 = none)
//             CNT_W         width of the retired-instruction counter
//  Ports    : clk, rst (async, active high)
//             bus  multicycle_controller_if.master (see interface header)
//  Config   : MC_ILLEGAL_TRAP_EN - unknown opcodes halt and set illegal_op;
//             when undefined they retire as a NOP.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
)(
    input  wire logic                clk,
    input  wire logic                rst,
    multicycle_controller_if.master  bus
);

    // Counter only needs to hold 0 .. MEM_WAIT_MAX-1: the cycle that would
    // reach MEM_WAIT_MAX is the timeout cycle itself.
    localparam int                  c_wait_w    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam bit                  c_timeout_en = (MEM_WAIT_MAX > 0);
    localparam logic [c_wait_w-1:0] c_wait_last =
        c_wait_w'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

    state_e              r_state;
    state_e              w_next;
    op_class_e           r_class;
    op_class_e           w_dec_class;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_instret;
    logic                r_bus_err;

    logic                w_in_access;
    logic                w_ack;
    logic                w_waiting;
    logic                w_timeout;

    logic                w_imem_req;
    logic                w_dmem_req;
    logic                w_dmem_we;
    logic                w_ir_write;
    logic                w_pc_write;
    logic [1:0]          w_pc_src;
    logic                w_reg_write;
    logic [2:0]          w_imm_src;
    logic [1:0]          w_alu_src_a;
    logic                w_alu_src_b;
    logic [1:0]          w_alu_op;
    logic [1:0]          w_wb_sel;

    instr_classifier u_classifier (
        .opcode   (bus.opcode),
        .op_class (w_dec_class)
    );

    // ------------------------------------------------------------------
    // Memory wait supervision. Ack in the deciding cycle beats the timeout.
    // ------------------------------------------------------------------
    assign w_in_access = (r_state == FETCH) || (r_state == MEM);
    assign w_ack       = (r_state == FETCH) ? bus.imem_ack : bus.dmem_ack;
    assign w_waiting   = w_in_access && !w_ack;
    assign w_timeout   = c_timeout_en && w_waiting && (r_wait_cnt == c_wait_last);

    // ------------------------------------------------------------------
    // State register and datapath-side bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class    <= LOAD;
            r_wait_cnt <= '0;
            r_instret  <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            // The opcode bus is only trusted in the acked fetch cycle.
            if (r_state == FETCH && bus.imem_ack) begin
                r_class <= w_dec_class;
            end
            if (c_timeout_en && w_waiting && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_pc_write) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_op <= 1'b0;
        end else if (r_state == DECODE && r_class == ILLEGAL) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign bus.illegal_op = r_illegal_op;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   w_next = FETCH;
            FETCH: begin
                if (bus.imem_ack)   w_next = DECODE;
                else if (w_timeout) w_next = HALT;
            end
            DECODE: begin
                if (r_class == ILLEGAL) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    w_next = HALT;
`else
                    w_next = FETCH;
`endif
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                case (r_class)
                    LOAD, STORE: w_next = MEM;
                    BRANCH:      w_next = FETCH;
                    default:     w_next = WB;
                endcase
            end
            MEM: begin
                if (bus.dmem_ack)   w_next = (r_class == LOAD) ? WB : FETCH;
                else if (w_timeout) w_next = HALT;
            end
            WB:     w_next = FETCH;
            HALT:   w_next = HALT;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: state plus latched class; the ack- and branch-qualified
    // strobes also look at the live inputs of the current cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = c_pc_plus4;
        w_reg_write = 1'b0;
        w_imm_src   = c_imm_i;
        w_alu_src_a = c_srca_rs1;
        w_alu_src_b = 1'b0;
        w_alu_op    = c_aluop_add;
        w_wb_sel    = c_wb_alu;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                w_ir_write = bus.imem_ack;
            end
            DECODE: begin
                w_imm_src = imm_src_for(r_class);
`ifndef MC_ILLEGAL_TRAP_EN
                // Unknown opcode retires as a NOP straight from decode.
                w_pc_write = (r_class == ILLEGAL);
`endif
            end
            EXEC: begin
                w_imm_src = imm_src_for(r_class);
                case (r_class)
                    LOAD, STORE: w_alu_src_b = 1'b1;
                    BRANCH: begin
                        w_alu_op   = c_aluop_br;
                        w_pc_write = 1'b1;
                        w_pc_src   = bus.br_taken ? c_pc_imm : c_pc_plus4;
                    end
                    RTYPE:  w_alu_op = c_aluop_funct;
                    ITYPE: begin
                        w_alu_op    = c_aluop_funct;
                        w_alu_src_b = 1'b1;
                    end
                    LUI: begin
                        w_alu_src_a = c_srca_zero;
                        w_alu_src_b = 1'b1;
                    end
                    AUIPC, JAL: begin
                        w_alu_src_a = c_srca_pc;
                        w_alu_src_b = 1'b1;
                    end
                    JALR:    w_alu_src_b = 1'b1;
                    default: ;
                endcase
            end
            MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_class == STORE);
                w_pc_write = (r_class == STORE) && bus.dmem_ack;
            end
            WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                case (r_class)
                    LOAD:    w_wb_sel = c_wb_mem;
                    JAL:     w_wb_sel = c_wb_pc4;
                    JALR:    w_wb_sel = c_wb_pc4;
                    default: w_wb_sel = c_wb_alu;
                endcase
                case (r_class)
                    JAL:     w_pc_src = c_pc_imm;
                    JALR:    w_pc_src = c_pc_alu;
                    default: w_pc_src = c_pc_plus4;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.dmem_req  = w_dmem_req;
    assign bus.dmem_we   = w_dmem_we;
    assign bus.ir_write  = w_ir_write;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.reg_write = w_reg_write;
    assign bus.imm_src   = w_imm_src;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.instret   = r_instret;
    assign bus.bus_err   = r_bus_err;
    assign bus.halted    = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Self-checking bench for multicycle_controller. Each instruction
//             is played as a transaction (random wait states, random noise on
//             ignored inputs) and every cycle is compared with the behaviour
//             the instruction class should show in that phase.
//  Config   : honours MC_ILLEGAL_TRAP_EN for the illegal-opcode path.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    localparam int K_LOAD = 0, K_STORE = 1, K_RTYPE = 2, K_ITYPE = 3, K_BRANCH = 4,
                   K_LUI = 5, K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(CW)) bus();

    multicycle_controller #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] opc_tab [0:8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111};

    int n_cmp   = 0;
    int n_err   = 0;
    int retired = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected immediate format per class; -1 where the class has none.
    function automatic int exp_imm(input int kind);
        case (kind)
            K_LOAD, K_ITYPE, K_JALR: return 0;
            K_STORE:                 return 1;
            K_BRANCH:                return 2;
            K_JAL:                   return 3;
            K_LUI, K_AUIPC:          return 4;
            default:                 return -1;
        endcase
    endfunction

    task automatic noise();
        bus.imem_ack = 1'($urandom);
        bus.dmem_ack = 1'($urandom);
        bus.opcode   = 7'($urandom);
        bus.br_taken = 1'($urandom);
    endtask

    task automatic strobes(input string ph, input bit e_ireq, input bit e_dreq, input bit e_we,
                           input bit e_ir, input bit e_pcw, input bit e_rw);
        check({ph, ".imem_req"},  bus.imem_req,  e_ireq);
        check({ph, ".dmem_req"},  bus.dmem_req,  e_dreq);
        check({ph, ".dmem_we"},   bus.dmem_we,   e_we);
        check({ph, ".ir_write"},  bus.ir_write,  e_ir);
        check({ph, ".pc_write"},  bus.pc_write,  e_pcw);
        check({ph, ".reg_write"}, bus.reg_write, e_rw);
        check({ph, ".halted"},    bus.halted,    0);
        check({ph, ".bus_err"},   bus.bus_err,   0);
        check({ph, ".instret"},   bus.instret,   retired % (1 << CW));
`ifdef MC_ILLEGAL_TRAP_EN
        check({ph, ".illegal_op"}, bus.illegal_op, 0);
`endif
        if (e_pcw) retired++;
    endtask

    // Asserts reset part-way through the current cycle, then releases it.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.imem_req",  bus.imem_req,  0);
        check("rst.dmem_req",  bus.dmem_req,  0);
        check("rst.dmem_we",   bus.dmem_we,   0);
        check("rst.ir_write",  bus.ir_write,  0);
        check("rst.pc_write",  bus.pc_write,  0);
        check("rst.reg_write", bus.reg_write, 0);
        check("rst.selects",   {bus.pc_src, bus.imm_src, bus.alu_src_a, bus.alu_src_b,
                                bus.alu_op, bus.wb_sel}, 0);
        check("rst.instret",   bus.instret,   0);
        check("rst.bus_err",   bus.bus_err,   0);
        check("rst.halted",    bus.halted,    0);
`ifdef MC_ILLEGAL_TRAP_EN
        check("rst.illegal_op", bus.illegal_op, 0);
`endif
        retired = 0;
        @(negedge clk);
        noise();
        rst = 1'b0;
        #1;
        strobes("idle", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_halt(input bit e_bus_err);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            noise();
            #1;
            check("halt.halted",   bus.halted,  1);
            check("halt.bus_err",  bus.bus_err, e_bus_err);
            check("halt.strobes",  {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write,
                                    bus.pc_write, bus.reg_write}, 0);
            check("halt.instret",  bus.instret, retired % (1 << CW));
`ifdef MC_ILLEGAL_TRAP_EN
            check("halt.illegal_op", bus.illegal_op, !e_bus_err);
`endif
        end
        do_reset();
    endtask

    // bt_sel: 0/1 forces br_taken in EXEC, anything else randomises it.
    // iw/dw >= MAXW means the ack never comes (timeout).
    task automatic run_instr(input int kind, input int iw, input int dw,
                             input int bt_sel, input bit rst_in_mem);
        logic [6:0] op;
        bit         bt;
        bit         is_st;
        int         ei;
        is_st = (kind == K_STORE);
        op    = (kind == K_ILL) ? 7'b1111111 : opc_tab[kind];

        for (int k = 0; k <= iw && k < MAXW; k++) begin
            @(negedge clk);
            noise();
            bus.imem_ack = (k == iw);
            bus.opcode   = (k == iw) ? op : 7'($urandom);
            #1;
            strobes("fetch", 1, 0, 0, k == iw, 0, 0);
        end
        if (iw >= MAXW) begin
            expect_halt(1'b1);
            return;
        end

        @(negedge clk);
        noise();
        #1;
        ei = exp_imm(kind);
        if (ei >= 0) check("decode.imm_src", bus.imm_src, ei);
        if (kind == K_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
            strobes("decode", 0, 0, 0, 0, 0, 0);
            expect_halt(1'b0);
`else
            strobes("decode", 0, 0, 0, 0, 1, 0);
            check("nop.pc_src", bus.pc_src, 0);
`endif
            return;
        end
        strobes("decode", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        noise();
        bt = (bt_sel == 0 || bt_sel == 1) ? bt_sel[0] : 1'($urandom);
        bus.br_taken = bt;
        #1;
        case (kind)
            K_LOAD, K_STORE, K_JALR: begin
                check("exec.alu_op", bus.alu_op, 0);
                check("exec.src_a",  bus.alu_src_a, 0);
                check("exec.src_b",  bus.alu_src_b, 1);
            end
            K_BRANCH: begin
                check("exec.alu_op", bus.alu_op, 1);
                check("exec.src_b",  bus.alu_src_b, 0);
            end
            K_RTYPE: begin
                check("exec.alu_op", bus.alu_op, 2);
                check("exec.src_b",  bus.alu_src_b, 0);
            end
            K_ITYPE: begin
                check("exec.alu_op", bus.alu_op, 2);
                check("exec.src_b",  bus.alu_src_b, 1);
            end
            K_LUI:   check("exec.src_a", bus.alu_src_a, 2);
            K_AUIPC: check("exec.src_a", bus.alu_src_a, 1);
            default: ;
        endcase
        if (kind == K_BRANCH) begin
            strobes("exec", 0, 0, 0, 0, 1, 0);
            check("branch.pc_src", bus.pc_src, bt ? 1 : 0);
            return;
        end
        strobes("exec", 0, 0, 0, 0, 0, 0);

        if (kind == K_LOAD || kind == K_STORE) begin
            for (int k = 0; k <= dw && k < MAXW; k++) begin
                @(negedge clk);
                noise();
                bus.dmem_ack = (k == dw);
                #1;
                strobes("mem", 0, 1, is_st, 0, is_st && (k == dw), 0);
                if (is_st && k == dw) check("store.pc_src", bus.pc_src, 0);
                if (rst_in_mem) begin
                    do_reset();
                    return;
                end
            end
            if (dw >= MAXW) begin
                expect_halt(1'b1);
                return;
            end
            if (is_st) return;
        end

        @(negedge clk);
        noise();
        #1;
        strobes("wb", 0, 0, 0, 0, 1, 1);
        check("wb.wb_sel", bus.wb_sel,
              (kind == K_LOAD) ? 1 : (kind == K_JAL || kind == K_JALR) ? 2 : 0);
        check("wb.pc_src", bus.pc_src,
              (kind == K_JAL) ? 1 : (kind == K_JALR) ? 2 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.opcode   = 7'd0;
        bus.br_taken = 1'b0;
        do_reset();

        run_instr(K_ITYPE,  0, 0, 2, 0);   // ADDI, zero wait
        run_instr(K_LOAD,   0, 3, 2, 0);   // LW, 3 data wait cycles
        run_instr(K_BRANCH, 0, 0, 1, 0);
        run_instr(K_BRANCH, 0, 0, 0, 0);
        run_instr(K_JALR,   0, 0, 2, 0);
        run_instr(K_LUI,    1, 0, 2, 0);
        run_instr(K_STORE,  2, 2, 2, 0);
        run_instr(K_JAL,    0, 0, 2, 0);
        run_instr(K_AUIPC,  0, 0, 2, 0);
        run_instr(K_RTYPE,  0, 0, 2, 0);

        // Random stream; enough retirements to wrap the 4-bit counter.
        for (int n = 0; n < 60; n++) begin
            run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, MAXW - 1)),
                      int'($urandom_range(0, MAXW - 1)), 2, 0);
        end

        run_instr(K_ITYPE, MAXW - 1, 0, 2, 0);  // ack in the last allowed cycle
        run_instr(K_ILL,   0, 0, 2, 0);
        run_instr(K_ITYPE, 0, 0, 2, 0);
        run_instr(K_ITYPE, MAXW, 0, 2, 0);      // fetch timeout
        run_instr(K_ITYPE, 0, 0, 2, 0);
        run_instr(K_LOAD,  0, MAXW, 2, 0);      // data timeout
        run_instr(K_STORE, 0, MAXW - 1, 2, 0);
        run_instr(K_LOAD,  0, 2, 2, 1);         // reset during MEM
        run_instr(K_ITYPE, 0, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
